led_chase_sequencer: RTL
========================

LED_CHASE_SEQUENCER -- requirements
Module: led_chase_sequencer

Interface
REQ-001 Parameters SHALL be:
- TICK_DIV, default 1000: clock cycles per brightness step.
- PWM_BITS, default 5: duty width; MAX = 2^PWM_BITS-1.
- HOLD_STEPS, default 4: ticks held at full brightness.
REQ-002 Ports SHALL be as follows; one clock, and reset is asynchronous and active-low:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous reset, active-low.
- mode  in  2: pattern select; 0 chase, 1 bounce, 2 all-channel breathe, 3 same as 0.
- start  in  1: one-cycle start request.
- stop  in  1: one-cycle stop request.
- busy  out  1: high in every state except IDLE.
- chan  out  3: currently sequenced channel index.
- done_pulse  out  1: one-cycle pulse at the end of each full pattern pass.
- led_out  out  8: registered PWM outputs.

Function
REQ-003 States SHALL be IDLE, UP, HOLD, DOWN, ADV.
REQ-004 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick = prescaler==TICK_DIV-1; the prescaler SHALL be held at 0 in IDLE and cleared on any sequence (re)start.
REQ-005 PWM counter SHALL free-run 0..MAX-1 and wrap; pwm_on = (pwm_cnt < duty); duty==MAX therefore gives 100% on and duty==0 gives 0%.
REQ-006 IDLE + start: latch mode into mode_r, chan=7, dir=down, duty=0, state=UP; busy SHALL rise on the next edge; start while busy SHALL be ignored.
REQ-007 UP, on tick: if duty==MAX go to HOLD with hold_cnt=0, else duty+1.
REQ-008 HOLD, on tick: hold_cnt+1; when hold_cnt==HOLD_STEPS-1, go to DOWN.
REQ-009 DOWN, on tick: if duty==0 go to ADV, else duty-1.
REQ-010 ADV SHALL last exactly one cycle, update chan/dir per REQ-011..013, then go to UP with duty=0 and prescaler=0.
REQ-011 Modes 0/3: chan decrements 7..0 and wraps 0->7; done_pulse SHALL fire in the ADV cycle where chan==0.
REQ-012 Mode 1 ADV rules:
- dir=down and chan==0: dir=up, chan=1.
- dir=up and chan==7: dir=down, chan=6, done_pulse.
- otherwise: step chan in dir.
REQ-013 Mode 2: chan SHALL stay 7; done_pulse SHALL fire in every ADV cycle.
REQ-014 led_out SHALL be registered: 0 in IDLE; in modes 0/1/3, bit chan = pwm_on and all other bits 0; in mode 2, all bits = pwm_on.
REQ-015 The sequence SHALL repeat indefinitely until stop.
REQ-016 stop while busy: next state IDLE; duty, led_out, busy, chan(=7) and hold_cnt cleared on the next edge.
REQ-017 mode != mode_r while busy: on the next edge SHALL reload mode_r, chan=7, dir=down, duty=0, prescaler=0, state=UP; no done_pulse.
REQ-018 Priority within one cycle SHALL be stop > mode change > start > state progression; stop and start together in IDLE SHALL stay in IDLE.
REQ-019 done_pulse SHALL never be high for two consecutive cycles.

Reset
REQ-020 When rst=0, all registers SHALL clear asynchronously: state=IDLE, busy=0, chan=7, dir=down, duty=0, hold_cnt=0, prescaler=0, pwm_cnt=0, mode_r=0, done_pulse=0, led_out=8'h00.
REQ-021 After rst deasserts, the block SHALL remain in IDLE until start.
REQ-022 rst asserted mid-sequence SHALL override all other inputs immediately.

Verification (TICK_DIV=2, PWM_BITS=2 so MAX=3, HOLD_STEPS=1)
REQ-023 Mode 0 start -> per channel: UP 4 ticks, HOLD 1 tick, DOWN 4 ticks, ADV 1 cycle; chan sequence 7,6,..,0; one done_pulse after chan 0; then chan=7.
REQ-024 Mode 1 -> chan sequence 7..0,1..7,6; done_pulse only at the ADV leaving chan 7 with dir=up.
REQ-025 Mode 2 -> led_out in {00,FF} only, FF duty 0/3..3/3 across the ramp; done_pulse every ADV.
REQ-026 stop during HOLD -> next edge busy=0, led_out=00, chan=7; start and stop in the same cycle in IDLE -> busy stays 0.
REQ-027 mode 0->1 mid-DOWN on chan 4 -> next edge chan=7, state UP, duty 0, no done_pulse.
REQ-028 rst low mid-UP, asynchronously between edges -> led_out=00 and busy=0 before the next clk edge.

Source files
------------

// File: rtl/led_chase_sequencer.sv
// LED chase / bounce / breathe sequencer: ramps one channel (or all channels)
// up, holds at full brightness, ramps down, then advances to the next channel.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | outputs dark, prescaler parked, waiting for start
// UP    | duty ramps 0 -> MAX, one step per tick
// HOLD  | duty held at MAX for HOLD_STEPS ticks
// DOWN  | duty ramps MAX -> 0, one step per tick
// ADV   | single cycle: pick next channel / direction
module led_chase_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int PWM_BITS   = 5,
  parameter int HOLD_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic [2:0] chan,
  output logic       done_pulse,
  output logic [7:0] led_out
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = DUTY_MAX - PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD,
    S_DOWN,
    S_ADV
  } state_t;

  state_t              state;
  logic [1:0]          mode_r;
  logic                dir_up;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic [HOLD_W-1:0]   hold_cnt;

  logic       tick;
  logic       pwm_on;
  logic       pass_end;
  logic [7:0] led_pat;

  assign tick   = (prescaler == PRE_LAST);
  assign pwm_on = (pwm_cnt < duty);

  // The ADV about to be entered closes a full pattern pass.
  always_comb begin
    pass_end = 1'b0;
    case (mode_r)
      2'd1:    pass_end = dir_up && (chan == 3'd7);
      2'd2:    pass_end = 1'b1;
      default: pass_end = (chan == 3'd0);
    endcase
  end

  always_comb begin
    led_pat = 8'h00;
    if (mode_r == 2'd2)
      led_pat = {8{pwm_on}};
    else if (pwm_on)
      led_pat = 8'h01 << chan;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      chan       <= 3'd7;
      dir_up     <= 1'b0;
      duty       <= '0;
      hold_cnt   <= '0;
      prescaler  <= '0;
      pwm_cnt    <= '0;
      mode_r     <= 2'd0;
      done_pulse <= 1'b0;
      led_out    <= 8'h00;
    end else begin
      pwm_cnt    <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      done_pulse <= 1'b0;

      if (state != S_IDLE && stop) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        chan      <= 3'd7;
        dir_up    <= 1'b0;
        duty      <= '0;
        hold_cnt  <= '0;
        prescaler <= '0;
        led_out   <= 8'h00;
      end else if (state != S_IDLE && mode != mode_r) begin
        // Pattern switched on the fly: restart cleanly in the new mode.
        mode_r    <= mode;
        state     <= S_UP;
        busy      <= 1'b1;
        chan      <= 3'd7;
        dir_up    <= 1'b0;
        duty      <= '0;
        hold_cnt  <= '0;
        prescaler <= '0;
        led_out   <= 8'h00;
      end else if (state == S_IDLE) begin
        prescaler <= '0;
        led_out   <= 8'h00;
        if (start && !stop) begin
          mode_r   <= mode;
          state    <= S_UP;
          busy     <= 1'b1;
          chan     <= 3'd7;
          dir_up   <= 1'b0;
          duty     <= '0;
          hold_cnt <= '0;
        end
      end else begin
        led_out   <= led_pat;
        prescaler <= tick ? '0 : prescaler + 1'b1;
        case (state)
          S_UP: begin
            if (tick) begin
              if (duty == DUTY_MAX) begin
                state    <= S_HOLD;
                hold_cnt <= '0;
              end else begin
                duty <= duty + 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (tick) begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt == HOLD_LAST)
                state <= S_DOWN;
            end
          end
          S_DOWN: begin
            if (tick) begin
              if (duty == '0) begin
                state      <= S_ADV;
                done_pulse <= pass_end;
              end else begin
                duty <= duty - 1'b1;
              end
            end
          end
          S_ADV: begin
            state     <= S_UP;
            duty      <= '0;
            prescaler <= '0;
            case (mode_r)
              2'd2: chan <= chan;
              2'd1: begin
                if (!dir_up && chan == 3'd0) begin
                  dir_up <= 1'b1;
                  chan   <= 3'd1;
                end else if (dir_up && chan == 3'd7) begin
                  dir_up <= 1'b0;
                  chan   <= 3'd6;
                end else begin
                  chan <= dir_up ? chan + 3'd1 : chan - 3'd1;
                end
              end
              default: chan <= chan - 3'd1;
            endcase
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
